// File: rtl/fb_pair_reader_pkg.sv
// Shared frame-buffer constants (common with the draw side) and the pair-reader FSM encoding.
package fb_pkg;

   localparam int FB_ADDR_W    = 14;
   localparam int FB_DATA_W    = 8;
   localparam int FB_BASE_WORD = 2816;
   localparam int FB_NUM_WORDS = 128;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ISSUE  = 3'd1,
      WAIT   = 3'd2,
      EMIT_A = 3'd3,
      EMIT_B = 3'd4,
      DONE   = 3'd5
   } fb_rd_state_t;

endpackage

// File: rtl/fb_pair_reader_if.sv
// Dual-port RAM read bus plus the outgoing valid/ready pixel stream of the pair reader.
interface fb_pair_reader_if
   import fb_pkg::*;
#(
   parameter int ADDR_W = FB_ADDR_W,
   parameter int DATA_W = FB_DATA_W
);
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr_a;
   logic [ADDR_W-1:0] rd_addr_b;
   logic [DATA_W-1:0] rd_data_a;
   logic [DATA_W-1:0] rd_data_b;
   logic [DATA_W-1:0] pix_data;
   logic              pix_valid;
   logic              pix_ready;
   logic              pix_last;

   modport master (
      output rd_en, rd_addr_a, rd_addr_b, pix_data, pix_valid, pix_last,
      input  rd_data_a, rd_data_b, pix_ready
   );

   modport slave (
      input  rd_en, rd_addr_a, rd_addr_b, pix_data, pix_valid, pix_last,
      output rd_data_a, rd_data_b, pix_ready
   );

endinterface

// File: rtl/fb_pair_reader_addr_gen.sv
// Pair-index counter for the frame-buffer reader; registers both port addresses from the index.
module fb_pair_addr_gen
   import fb_pkg::*;
#(
   parameter int ADDR_W    = FB_ADDR_W,
   parameter int BASE_WORD = FB_BASE_WORD,
   parameter int NUM_WORDS = FB_NUM_WORDS
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              inc,
   output logic [ADDR_W-2:0] idx,
   output logic              is_last,
   output logic [ADDR_W-1:0] rd_addr_a,
   output logic [ADDR_W-1:0] rd_addr_b
);

   localparam int IDX_W = ADDR_W - 1;
   localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(BASE_WORD);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BASE_WORD + NUM_WORDS - 1);

   // The index must never wrap inside a frame.
   if (NUM_WORDS < 1 || BASE_WORD + NUM_WORDS > 2 ** IDX_W) begin : g_range_check
      $error("fb_pair_addr_gen: pair range does not fit the address space");
   end

   logic [IDX_W-1:0] idx_nxt;

   // Next index: reload on frame start, step after each emitted pair.
   always_comb begin
      idx_nxt = idx;
      if (load) begin
         idx_nxt = FIRST_IDX;
      end else if (inc) begin
         idx_nxt = idx + {{(IDX_W-1){1'b0}}, 1'b1};
      end else begin
         idx_nxt = idx;
      end
   end

   // Addresses update together with the index so they always reflect it.
   always_ff @(posedge clk) begin
      if (!reset) begin
         idx       <= FIRST_IDX;
         rd_addr_a <= {FIRST_IDX, 1'b0};
         rd_addr_b <= {FIRST_IDX, 1'b1};
      end else begin
         idx       <= idx_nxt;
         rd_addr_a <= {idx_nxt, 1'b0};
         rd_addr_b <= {idx_nxt, 1'b1};
      end
   end

   assign is_last = (idx == LAST_IDX);

endmodule

// File: rtl/fb_pair_reader.sv
// Frame-buffer pair reader: reads A/B words per pair and serialises them as a pixel stream.
// Optional FB_READER_CONTINUOUS_EN: a start seen in DONE chains straight into the next frame.
module fb_pair_reader
   import fb_pkg::*;
#(
   parameter int ADDR_W    = FB_ADDR_W,
   parameter int DATA_W    = FB_DATA_W,
   parameter int BASE_WORD = FB_BASE_WORD,
   parameter int NUM_WORDS = FB_NUM_WORDS
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   fb_pair_reader_if.master  bus
);

   fb_rd_state_t      state;
   fb_rd_state_t      state_nxt;
   logic              load;
   logic              inc;
   logic              is_last;
   logic [ADDR_W-1:0] addr_a;
   logic [ADDR_W-1:0] addr_b;
   logic [DATA_W-1:0] hold_a;
   logic [DATA_W-1:0] hold_b;
   logic              rd_en;
   logic [DATA_W-1:0] pix_data;
   logic              pix_valid;
   logic              pix_last;

   fb_pair_addr_gen #(
      .ADDR_W    (ADDR_W),
      .BASE_WORD (BASE_WORD),
      .NUM_WORDS (NUM_WORDS)
   ) u_addr_gen (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .inc       (inc),
      .idx       (),
      .is_last   (is_last),
      .rd_addr_a (addr_a),
      .rd_addr_b (addr_b)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic and counter controls.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      inc       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = ISSUE;
            end else begin
               state_nxt = IDLE;
            end
         end
         ISSUE:  state_nxt = WAIT;
         WAIT:   state_nxt = EMIT_A;
         EMIT_A: begin
            if (bus.pix_ready) begin
               state_nxt = EMIT_B;
            end else begin
               state_nxt = EMIT_A;
            end
         end
         EMIT_B: begin
            if (bus.pix_ready && is_last) begin
               state_nxt = DONE;
            end else if (bus.pix_ready) begin
               inc       = 1'b1;
               state_nxt = ISSUE;
            end else begin
               state_nxt = EMIT_B;
            end
         end
         DONE: begin
`ifdef FB_READER_CONTINUOUS_EN
            if (start) begin
               load      = 1'b1;
               state_nxt = ISSUE;
            end else begin
               state_nxt = IDLE;
            end
`else
            state_nxt = IDLE;
`endif
         end
         default: state_nxt = IDLE;
      endcase
   end

   // RAM data is valid during WAIT (read latency 1 after ISSUE).
   always_ff @(posedge clk) begin
      if (!reset) begin
         hold_a <= {DATA_W{1'b0}};
         hold_b <= {DATA_W{1'b0}};
      end else if (state == WAIT) begin
         hold_a <= bus.rd_data_a;
         hold_b <= bus.rd_data_b;
      end else begin
         hold_a <= hold_a;
         hold_b <= hold_b;
      end
   end

   // Outputs decode purely from registered state and hold data, so they stay stable under stall.
   always_comb begin
      busy      = 1'b1;
      done      = 1'b0;
      rd_en     = 1'b0;
      pix_valid = 1'b0;
      pix_data  = {DATA_W{1'b0}};
      pix_last  = 1'b0;
      case (state)
         IDLE:   busy = 1'b0;
         ISSUE:  rd_en = 1'b1;
         WAIT:   rd_en = 1'b0;
         EMIT_A: begin
            pix_valid = 1'b1;
            pix_data  = hold_a;
         end
         EMIT_B: begin
            pix_valid = 1'b1;
            pix_data  = hold_b;
            pix_last  = is_last;
         end
         DONE:   done = 1'b1;
         default: busy = 1'b0;
      endcase
   end

   assign bus.rd_en     = rd_en;
   assign bus.rd_addr_a = addr_a;
   assign bus.rd_addr_b = addr_b;
   assign bus.pix_data  = pix_data;
   assign bus.pix_valid = pix_valid;
   assign bus.pix_last  = pix_last;

endmodule

// File: tb/tb_fb_pair_reader.sv
// Self-checking bench for fb_pair_reader: scoreboard of expected pixels, directed frame scenarios.
module tb_fb_pair_reader;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic start0 = 1'b0;
   logic start1 = 1'b0;
   logic busy0, done0, busy1, done1;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int last_cyc = -100;
   int rd_cnt = 0;
   int pix_cnt = 0;
   int done_cnt = 0;
   logic       stall_prev = 1'b0;
   logic [7:0] prev_data = 8'h00;
   logic       prev_last = 1'b0;
   exp_t       exp_q[$];
   exp_t       e;

   fb_pair_reader_if #(.ADDR_W(14), .DATA_W(8)) b0();
   fb_pair_reader_if #(.ADDR_W(14), .DATA_W(8)) b1();

   fb_pair_reader #(.ADDR_W(14), .DATA_W(8), .BASE_WORD(2816), .NUM_WORDS(128)) u_dut0 (
      .clk(clk), .reset(reset), .start(start0), .busy(busy0), .done(done0), .bus(b0)
   );

   fb_pair_reader #(.ADDR_W(14), .DATA_W(8), .BASE_WORD(0), .NUM_WORDS(1)) u_dut1 (
      .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1), .bus(b1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // RAM models: data = low byte of address, one cycle after rd_en
   always @(posedge clk) begin
      if (b0.rd_en) begin
         b0.rd_data_a <= b0.rd_addr_a[7:0];
         b0.rd_data_b <= b0.rd_addr_b[7:0];
      end
      if (b1.rd_en) begin
         b1.rd_data_a <= b1.rd_addr_a[7:0];
         b1.rd_data_b <= b1.rd_addr_b[7:0];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic push_frame();
      exp_t t;
      logic [13:0] a;
      for (int i = 0; i < 256; i++) begin
         a = 14'(5632 + i);
         t.data = a[7:0];
         t.last = (i == 255);
         exp_q.push_back(t);
      end
   endtask

   task automatic run_frame(input int limit, input bit rnd);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < limit && !seen; c++) begin
         @(posedge clk);
         #1;
         b0.pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk);
         if (done0) seen = 1'b1;
      end
      chk("done_seen", 32'(seen), 32'd1);
   endtask

   // Scoreboard pop on each transfer, plus stall stability and done timing
   always @(negedge clk) begin
      if (reset) begin
         if (b0.rd_en) rd_cnt++;
         if (done0) begin
            done_cnt++;
            chk("done_after_last", 32'(cyc - last_cyc), 32'd1);
         end
         if (stall_prev) begin
            chk("stall_data", 32'(b0.pix_data), 32'(prev_data));
            chk("stall_last", 32'(b0.pix_last), 32'(prev_last));
            chk("stall_valid", 32'(b0.pix_valid), 32'd1);
         end
         if (b0.pix_valid && b0.pix_ready) begin
            pix_cnt++;
            if (exp_q.size() == 0) begin
               chk("extra_pixel", 32'(exp_q.size()), 32'd1);
            end else begin
               e = exp_q.pop_front();
               chk("pix_data", 32'(b0.pix_data), 32'(e.data));
               chk("pix_last", 32'(b0.pix_last), 32'(e.last));
            end
            if (b0.pix_last) last_cyc = cyc;
         end
         stall_prev = b0.pix_valid && !b0.pix_ready;
         prev_data  = b0.pix_data;
         prev_last  = b0.pix_last;
      end else begin
         stall_prev = 1'b0;
      end
   end

   initial begin
      int         lat;
      int         n1;
      int         done_base;
      bit         found;
      bit         seen1;
      logic [7:0] d1[2];
      logic       l1[2];

      b0.pix_ready = 1'b0;
      b1.pix_ready = 1'b0;

      // 1: reset state
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      chk("rst_busy", 32'(busy0), 32'd0);
      chk("rst_valid", 32'(b0.pix_valid), 32'd0);
      chk("rst_done", 32'(done0), 32'd0);
      chk("rst_rd_en", 32'(b0.rd_en), 32'd0);
      chk("rst_addr_a", 32'(b0.rd_addr_a), 32'd5632);
      chk("rst_addr_b", 32'(b0.rd_addr_b), 32'd5633);
      chk("rst_addr_b_1", 32'(b1.rd_addr_b), 32'd1);

      // 2: full frame, ready tied high, latency check
      exp_q.delete();
      push_frame();
      rd_cnt = 0;
      pix_cnt = 0;
      @(posedge clk);
      #1;
      b0.pix_ready = 1'b1;
      start0 = 1'b1;
      @(posedge clk);
      #1;
      start0 = 1'b0;
      lat = 1;
      @(negedge clk);
      chk("issue_rd_en", 32'(b0.rd_en), 32'd1);
      chk("issue_busy", 32'(busy0), 32'd1);
      while (!b0.pix_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      chk("start_latency", 32'(lat), 32'd3);
      run_frame(2000, 1'b0);
      chk("f1_queue_empty", 32'(exp_q.size()), 32'd0);
      chk("f1_pix_cnt", 32'(pix_cnt), 32'd256);
      chk("f1_rd_cnt", 32'(rd_cnt), 32'd128);
      @(negedge clk);
      chk("f1_busy_drop", 32'(busy0), 32'd0);

      // 3: random backpressure
      push_frame();
      rd_cnt = 0;
      pix_cnt = 0;
      @(posedge clk);
      #1;
      start0 = 1'b1;
      @(posedge clk);
      #1;
      start0 = 1'b0;
      run_frame(5000, 1'b1);
      chk("f2_queue_empty", 32'(exp_q.size()), 32'd0);
      chk("f2_pix_cnt", 32'(pix_cnt), 32'd256);
      chk("f2_rd_cnt", 32'(rd_cnt), 32'd128);

      // 4: start held high across the frame
      push_frame();
      rd_cnt = 0;
      pix_cnt = 0;
      @(posedge clk);
      #1;
      start0 = 1'b1;
      run_frame(5000, 1'b1);
`ifdef FB_READER_CONTINUOUS_EN
      push_frame();
      @(posedge clk);
      #1;
      start0 = 1'b0;
      @(negedge clk);
      chk("f3_busy_chain", 32'(busy0), 32'd1);
      run_frame(5000, 1'b1);
      chk("f3_pix_cnt", 32'(pix_cnt), 32'd512);
      chk("f3_rd_cnt", 32'(rd_cnt), 32'd256);
      @(negedge clk);
      chk("f3_busy_drop", 32'(busy0), 32'd0);
`else
      @(posedge clk);
      #1;
      start0 = 1'b0;
      @(negedge clk);
      chk("f3_no_restart", 32'(busy0), 32'd0);
      repeat (4) @(negedge clk);
      chk("f3_still_idle", 32'(busy0), 32'd0);
      chk("f3_pix_cnt", 32'(pix_cnt), 32'd256);
      chk("f3_rd_cnt", 32'(rd_cnt), 32'd128);
`endif
      chk("f3_queue_empty", 32'(exp_q.size()), 32'd0);

      // 5: reset during EMIT_B of pair 40 (A word at 5712 = 0x1650)
      push_frame();
      done_base = done_cnt;
      found = 1'b0;
      b0.pix_ready = 1'b1;
      @(posedge clk);
      #1;
      start0 = 1'b1;
      @(posedge clk);
      #1;
      start0 = 1'b0;
      for (int c = 0; c < 2000 && !found; c++) begin
         @(negedge clk);
         if (b0.pix_valid && b0.pix_data == 8'h50) found = 1'b1;
      end
      chk("pair40_found", 32'(found), 32'd1);
      @(posedge clk);
      #1;
      chk("pair40_b_word", 32'(b0.pix_data), 32'h51);
      reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("abort_busy", 32'(busy0), 32'd0);
      chk("abort_valid", 32'(b0.pix_valid), 32'd0);
      chk("abort_addr_a", 32'(b0.rd_addr_a), 32'd5632);
      @(posedge clk);
      #1;
      reset = 1'b1;
      repeat (5) @(negedge clk);
      chk("abort_no_done", 32'(done_cnt - done_base), 32'd0);
      exp_q.delete();

      push_frame();
      rd_cnt = 0;
      pix_cnt = 0;
      @(posedge clk);
      #1;
      start0 = 1'b1;
      @(posedge clk);
      #1;
      start0 = 1'b0;
      @(negedge clk);
      chk("restart_addr_a", 32'(b0.rd_addr_a), 32'd5632);
      run_frame(5000, 1'b1);
      chk("f4_queue_empty", 32'(exp_q.size()), 32'd0);
      chk("f4_rd_cnt", 32'(rd_cnt), 32'd128);

      // 6: single-pair instance at base 0
      n1 = 0;
      seen1 = 1'b0;
      d1[0] = 8'hxx;
      d1[1] = 8'hxx;
      l1[0] = 1'bx;
      l1[1] = 1'bx;
      @(posedge clk);
      #1;
      b1.pix_ready = 1'b1;
      start1 = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (b1.pix_valid && b1.pix_ready) begin
            if (n1 < 2) begin
               d1[n1] = b1.pix_data;
               l1[n1] = b1.pix_last;
            end
            n1++;
         end
         if (done1) seen1 = 1'b1;
      end
      chk("one_count", 32'(n1), 32'd2);
      chk("one_data0", 32'(d1[0]), 32'h00);
      chk("one_data1", 32'(d1[1]), 32'h01);
      chk("one_last0", 32'(l1[0]), 32'd0);
      chk("one_last1", 32'(l1[1]), 32'd1);
      chk("one_done", 32'(seen1), 32'd1);
      chk("one_idle", 32'(busy1), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
